// File: rtl/regfile_writeback_arbiter_if.sv
// Write-port sharing bus between the pipeline writeback (A), the multi-cycle
// unit (B) and the register file write port.
interface regfile_writeback_arbiter_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned PW = $clog2(DEPTH) + 1;
  localparam int unsigned RW = 5;

  logic          a_valid;
  logic [RW-1:0] a_reg;
  logic [N-1:0]  a_data;
  logic          a_stall;

  logic          b_valid;
  logic [RW-1:0] b_reg;
  logic [N-1:0]  b_data;
  logic          b_ready;
  logic [PW-1:0] b_pending;

  logic          WriteEn;
  logic [RW-1:0] WriteReg;
  logic [N-1:0]  wd3;

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  a_stall, b_ready, b_pending, WriteEn, WriteReg, wd3
  );

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_stall, b_ready, b_pending, WriteEn, WriteReg, wd3
  );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Arbitrates the single register-file write port between fixed-priority
// writeback A and FIFO-buffered producer B, with bounded starvation of B.
module regfile_writeback_arbiter #(
  parameter int unsigned N            = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic Clock,
  input  logic R,
  regfile_writeback_arbiter_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned RW = 5;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] starve;
  logic [SW-1:0] starve_nxt;

  logic [RW-1:0] mem_reg  [DEPTH];
  logic [N-1:0]  mem_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [PW-1:0] count;

  logic a_req;
  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic grant_a;
  logic grant_b;

  // Request qualification; writes to x0 never reach the port
  assign a_req      = bus.a_valid && (bus.a_reg != '0);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == PW'(DEPTH));
  assign bus.b_ready   = !R && !fifo_full;
  assign push          = bus.b_valid && bus.b_ready && (bus.b_reg != '0);
  assign bus.b_pending = count;

  // State register
  always_ff @(posedge Clock or posedge R) begin
    if (R) begin
      state  <= NORMAL;
      starve <= '0;
    end else begin
      state  <= state_nxt;
      starve <= starve_nxt;
    end
  end

  // Next state: starvation counter and NORMAL/FORCE transitions
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve;
    if (grant_b || fifo_empty) begin
      starve_nxt = '0;
    end else if ((state == NORMAL) && grant_a && (starve != SW'(STARVE_LIMIT))) begin
      starve_nxt = starve + SW'(1);
    end
    unique case (state)
      NORMAL: if (starve_nxt == SW'(STARVE_LIMIT)) state_nxt = FORCE;
      FORCE:  if (grant_b) state_nxt = NORMAL;
    endcase
  end

  // Outputs: grant decision and Moore stall
  always_comb begin
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    bus.a_stall = (state == FORCE);
    unique case (state)
      NORMAL: begin
        grant_a = a_req;
        grant_b = !a_req && !fifo_empty;
      end
      FORCE: begin
        grant_b = !fifo_empty;
      end
    endcase
  end

  // FIFO storage; contents are qualified by count so no reset is needed
  always_ff @(posedge Clock) begin
    if (push) begin
      mem_reg[wr_ptr]  <= bus.b_reg;
      mem_data[wr_ptr] <= bus.b_data;
    end
  end

  // FIFO pointers and occupancy; pops see only entries pushed in earlier cycles
  always_ff @(posedge Clock or posedge R) begin
    if (R) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + AW'(1);
      if (grant_b) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, grant_b})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered register-file write port; address/data hold when idle
  always_ff @(posedge Clock or posedge R) begin
    if (R) begin
      bus.WriteEn  <= 1'b0;
      bus.WriteReg <= '0;
      bus.wd3      <= '0;
    end else if (grant_a) begin
      bus.WriteEn  <= 1'b1;
      bus.WriteReg <= bus.a_reg;
      bus.wd3      <= bus.a_data;
    end else if (grant_b) begin
      bus.WriteEn  <= 1'b1;
      bus.WriteReg <= mem_reg[rd_ptr];
      bus.wd3      <= mem_data[rd_ptr];
    end else begin
      bus.WriteEn  <= 1'b0;
    end
  end

endmodule
